// File: rtl/sum_ram_mc_pkg.sv
// rtl/sum_ram_mc_pkg.sv - shared state type and latency constants for the partial-sum RAM
package cnna_acc_pkg;

    // controller phases: idle after reset, accumulating, draining the RMW pipe, ready for readout
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        RDY   = 2'd3
    } acc_state_t;

    // beat-to-write depth of the read-modify-write pipe (t1..t4)
    localparam int RMW_LAT = 4;

    // request-to-data latency of the readout port
    localparam int DRAIN_LAT = 3;

endpackage

// File: rtl/sum_ram_mc_if.sv
// rtl/sum_ram_mc_if.sv - control, beat and readout bundle of the partial-sum RAM
interface sum_ram_mc_if #(
    parameter int C_LANES = 8,
    parameter int C_ISIZE = 12,
    parameter int C_DSIZE = 24,
    parameter int C_ASIZE = 10
);
    logic                         I_start;
    logic [C_ASIZE-1:0]           I_len;
    logic                         I_first_flag;
    logic                         I_dv;
    logic [C_LANES*C_ISIZE-1:0]   I_din;
    logic                         I_done;
    logic                         I_rd_req;
    logic [C_ASIZE-1:0]           I_raddr;
    logic                         O_busy;
    logic                         O_rvalid;
    logic [C_LANES*C_DSIZE-1:0]   O_rdata;

    modport master (
        output I_start, I_len, I_first_flag, I_dv, I_din, I_done, I_rd_req, I_raddr,
        input  O_busy, O_rvalid, O_rdata
    );

    modport slave (
        input  I_start, I_len, I_first_flag, I_dv, I_din, I_done, I_rd_req, I_raddr,
        output O_busy, O_rvalid, O_rdata
    );

endinterface

// File: rtl/sum_ram_mc_lane_add.sv
// rtl/sum_ram_mc_lane_add.sv - one lane: sign-extend, add, optional clamp (SUM_RAM_MC_SAT_EN), one register
module sum_lane_add #(
    parameter int C_ISIZE = 12,
    parameter int C_DSIZE = 24
) (
    input  logic               I_clk,
    input  logic [C_DSIZE-1:0] I_acc,
    input  logic [C_ISIZE-1:0] I_din,
    output logic [C_DSIZE-1:0] O_sum
);

    logic [C_DSIZE-1:0] din_ext;
    logic [C_DSIZE-1:0] sum_d;

    assign din_ext = {{(C_DSIZE-C_ISIZE){I_din[C_ISIZE-1]}}, I_din};

`ifdef SUM_RAM_MC_SAT_EN
    // one guard bit exposes overflow: the two top bits disagree only when the true sum is out of range
    logic [C_DSIZE:0] sum_wide;

    assign sum_wide = {I_acc[C_DSIZE-1], I_acc} + {din_ext[C_DSIZE-1], din_ext};

    // clamp to the most negative / most positive code on overflow
    always_comb begin
        sum_d = sum_wide[C_DSIZE-1:0];
        if (sum_wide[C_DSIZE] != sum_wide[C_DSIZE-1]) begin
            sum_d = sum_wide[C_DSIZE] ? {1'b1, {(C_DSIZE-1){1'b0}}}
                                      : {1'b0, {(C_DSIZE-1){1'b1}}};
        end
    end
`else
    // plain two's-complement add, wrapping modulo 2**C_DSIZE
    assign sum_d = I_acc + din_ext;
`endif

    // t3 sum register; also the youngest forwarding source
    always_ff @(posedge I_clk) begin
        O_sum <= sum_d;
    end

endmodule

// File: rtl/sum_ram_mc.sv
// rtl/sum_ram_mc.sv - multi-lane partial-sum accumulation RAM with RAW forwarding and drain port; SUM_RAM_MC_SAT_EN selects saturating lanes
module sum_ram_mc #(
    parameter     C_MEM_STYLE = "block",
    parameter int C_LANES     = 8,
    parameter int C_ISIZE     = 12,
    parameter int C_DSIZE     = 24,
    parameter int C_ASIZE     = 10
) (
    input  logic         I_clk,
    input  logic         I_rst,
    sum_ram_mc_if.slave  bus
);
    import cnna_acc_pkg::*;

    localparam int C_IW = C_LANES * C_ISIZE;
    localparam int C_DW = C_LANES * C_DSIZE;

    acc_state_t          state_q;
    acc_state_t          state_d;
    logic                load;

    logic [C_ASIZE-1:0]  cnt_q;
    logic [C_ASIZE-1:0]  len_q;
    logic                first_pass_q;

    logic                beat;
    logic                rd_acc;

    logic [RMW_LAT:1]    pv_q;
    logic [C_ASIZE-1:0]  s1_addr_q;
    logic [C_ASIZE-1:0]  s2_addr_q;
    logic [C_ASIZE-1:0]  s3_addr_q;
    logic [C_ASIZE-1:0]  s4_addr_q;
    logic                s1_first_q;
    logic                s2_first_q;
    logic [C_IW-1:0]     s1_din_q;
    logic [C_IW-1:0]     s2_din_q;
    logic [C_DW-1:0]     s3_sum;
    logic [C_DW-1:0]     s4_wdata_q;

    logic [C_DW-1:0]     ram_dout;
    logic [C_DW-1:0]     fwd;
    logic [C_DW-1:0]     acc_opnd;
    logic                ram_we;

    logic [DRAIN_LAT-1:0] rdp_q;
    logic                 rvalid_q;
    logic [C_DW-1:0]      rdata_q;

    assign beat   = (state_q == ACC) && bus.I_dv;
    assign rd_acc = (state_q == RDY) && bus.I_rd_req;

    // state register
    always_ff @(posedge I_clk) begin
        if (I_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state; start only takes effect from IDLE or RDY, drain waits for every RMW stage to retire
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.I_start) begin
                    state_d = ACC;
                    load    = 1'b1;
                end
            end
            ACC: begin
                if (bus.I_done) state_d = DRAIN;
            end
            DRAIN: begin
                if (pv_q == '0) state_d = RDY;
            end
            RDY: begin
                if (bus.I_start) begin
                    state_d = ACC;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // row address counter; the first-pass flag stays set until the first wrap
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            cnt_q        <= '0;
            len_q        <= '0;
            first_pass_q <= 1'b0;
        end else if (load) begin
            cnt_q        <= '0;
            len_q        <= bus.I_len;
            first_pass_q <= bus.I_first_flag;
        end else if (beat) begin
            if (cnt_q == len_q) begin
                cnt_q        <= '0;
                first_pass_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // stage valids; clearing them on reset flushes every in-flight beat
    always_ff @(posedge I_clk) begin
        if (I_rst) pv_q <= '0;
        else       pv_q <= {pv_q[RMW_LAT-1:1], beat};
    end

    // stage payloads; the t1 address doubles as the readout address while in RDY
    always_ff @(posedge I_clk) begin
        s1_addr_q  <= beat ? cnt_q : bus.I_raddr;
        s1_first_q <= first_pass_q;
        s1_din_q   <= bus.I_din;
        s2_addr_q  <= s1_addr_q;
        s2_first_q <= s1_first_q;
        s2_din_q   <= s1_din_q;
        s3_addr_q  <= s2_addr_q;
        s4_addr_q  <= s3_addr_q;
        s4_wdata_q <= s3_sum;
    end

    // RAW forwarding at t2: the youngest matching in-flight sum beats the RAM word; first pass starts from zero
    always_comb begin
        fwd = ram_dout;
        if (pv_q[4] && (s4_addr_q == s2_addr_q)) fwd = s4_wdata_q;
        if (pv_q[3] && (s3_addr_q == s2_addr_q)) fwd = s3_sum;
        acc_opnd = s2_first_q ? '0 : fwd;
    end

    genvar k;
    generate
        for (k = 0; k < C_LANES; k++) begin : g_lane
            sum_lane_add #(
                .C_ISIZE (C_ISIZE),
                .C_DSIZE (C_DSIZE)
            ) u_add (
                .I_clk (I_clk),
                .I_acc (acc_opnd[k*C_DSIZE +: C_DSIZE]),
                .I_din (s2_din_q[k*C_ISIZE +: C_ISIZE]),
                .O_sum (s3_sum[k*C_DSIZE +: C_DSIZE])
            );
        end
    endgenerate

    // a write landing in the reset cycle belongs to the aborted row and is dropped
    assign ram_we = pv_q[4] && !I_rst;

    sum_ram_mc_sdpram #(
        .C_MEM_STYLE (C_MEM_STYLE),
        .C_WIDTH     (C_DW),
        .C_ASIZE     (C_ASIZE)
    ) u_ram (
        .I_clk   (I_clk),
        .I_we    (ram_we),
        .I_waddr (s4_addr_q),
        .I_wdata (s4_wdata_q),
        .I_raddr (s1_addr_q),
        .O_rdata (ram_dout)
    );

    // readout pipe: request, address register, RAM word, output register; data holds between requests
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rdp_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rdp_q    <= {rdp_q[DRAIN_LAT-2:0], rd_acc};
            rvalid_q <= rdp_q[DRAIN_LAT-2];
            if (rdp_q[DRAIN_LAT-2]) rdata_q <= ram_dout;
        end
    end

    assign bus.O_busy   = (state_q == ACC) || (state_q == DRAIN);
    assign bus.O_rvalid = rvalid_q;
    assign bus.O_rdata  = rdata_q;

endmodule

// simple dual-port RAM, one write and one registered read port
module sum_ram_mc_sdpram #(
    parameter     C_MEM_STYLE = "block",
    parameter int C_WIDTH     = 8,
    parameter int C_ASIZE     = 4
) (
    input  logic               I_clk,
    input  logic               I_we,
    input  logic [C_ASIZE-1:0] I_waddr,
    input  logic [C_WIDTH-1:0] I_wdata,
    input  logic [C_ASIZE-1:0] I_raddr,
    output logic [C_WIDTH-1:0] O_rdata
);

    logic [C_WIDTH-1:0] mem [0:(1<<C_ASIZE)-1];

    // write port
    always_ff @(posedge I_clk) begin
        if (I_we) mem[I_waddr] <= I_wdata;
    end

    // write-first on a same-cycle collision: a beat three behind its producer reads the sum being written
    generate
        if (C_MEM_STYLE == "block") begin : g_block
            // read straight into the output register
            always_ff @(posedge I_clk) begin
                O_rdata <= (I_we && (I_waddr == I_raddr)) ? I_wdata : mem[I_raddr];
            end
        end else begin : g_dist
            logic [C_WIDTH-1:0] rd_async;

            assign rd_async = mem[I_raddr];

            // register the asynchronous read so both styles share one latency
            always_ff @(posedge I_clk) begin
                O_rdata <= (I_we && (I_waddr == I_raddr)) ? I_wdata : rd_async;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sum_ram_mc.sv
// tb/tb_sum_ram_mc.sv - randomized scoreboard bench for sum_ram_mc against a per-address lane model
module tb_sum_ram_mc;
    localparam int LANES = 8;
    localparam int ISIZE = 12;
    localparam int DSIZE = 14;
    localparam int ASIZE = 10;
    localparam int IW    = LANES * ISIZE;
    localparam int DW    = LANES * DSIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sum_ram_mc_if #(.C_LANES(LANES), .C_ISIZE(ISIZE), .C_DSIZE(DSIZE), .C_ASIZE(ASIZE)) bus ();

    sum_ram_mc #(
        .C_MEM_STYLE ("block"),
        .C_LANES     (LANES),
        .C_ISIZE     (ISIZE),
        .C_DSIZE     (DSIZE),
        .C_ASIZE     (ASIZE)
    ) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    longint        mdl [16][LANES];
    int            m_cnt, m_len;
    bit            m_first;
    logic [DW-1:0] exp_q [$];
    int            iss_q [$];
    logic [DW-1:0] mon_e;
    int            mon_t;

    function automatic longint norm(longint v);
        longint hi;
        hi = (longint'(1) <<< (DSIZE-1)) - 1;
`ifdef SUM_RAM_MC_SAT_EN
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
`else
        begin
            longint m;
            longint r;
            m = longint'(1) <<< DSIZE;
            r = ((v % m) + m) % m;
            if (r > hi) r = r - m;
            return r;
        end
`endif
    endfunction

    function automatic longint lane_in(logic [IW-1:0] v, int k);
        logic signed [ISIZE-1:0] s;
        s = v[k*ISIZE +: ISIZE];
        return longint'(s);
    endfunction

    function automatic logic [DW-1:0] exp_vec(int a);
        logic [DW-1:0] r;
        logic [63:0]   t;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            t = mdl[a][k];
            r[k*DSIZE +: DSIZE] = t[DSIZE-1:0];
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] vec_const(int v);
        logic [IW-1:0] r;
        logic [31:0]   t;
        t = v;
        for (int k = 0; k < LANES; k++) r[k*ISIZE +: ISIZE] = t[ISIZE-1:0];
        return r;
    endfunction

    function automatic logic [IW-1:0] vec_lane_idx();
        logic [IW-1:0] r;
        logic [31:0]   t;
        for (int k = 0; k < LANES; k++) begin
            t = k;
            r[k*ISIZE +: ISIZE] = t[ISIZE-1:0];
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] vec_rand();
        logic [IW-1:0] r;
        logic [31:0]   t;
        for (int k = 0; k < LANES; k++) begin
            t = $urandom;
            r[k*ISIZE +: ISIZE] = t[ISIZE-1:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic do_start(int len, bit first);
        bus.I_start      = 1'b1;
        bus.I_len        = ASIZE'(len);
        bus.I_first_flag = first;
        tick();
        bus.I_start = 1'b0;
        m_len   = len;
        m_cnt   = 0;
        m_first = first;
    endtask

    task automatic beat(logic [IW-1:0] din, bit with_done);
        bus.I_dv   = 1'b1;
        bus.I_din  = din;
        bus.I_done = with_done;
        tick();
        bus.I_dv   = 1'b0;
        bus.I_done = 1'b0;
        for (int k = 0; k < LANES; k++)
            mdl[m_cnt][k] = norm((m_first ? 64'sd0 : mdl[m_cnt][k]) + lane_in(din, k));
        if (m_cnt == m_len) begin
            m_cnt   = 0;
            m_first = 1'b0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (bus.O_busy && n < 30) begin
            tick();
            n++;
        end
        chk("drain_exit_busy", longint'(bus.O_busy), 0);
    endtask

    task automatic end_row();
        bus.I_done = 1'b1;
        tick();
        bus.I_done = 1'b0;
        wait_rdy();
    endtask

    task automatic drain(int lo, int hi);
        int n;
        for (int a = lo; a <= hi; a++) begin
            bus.I_rd_req = 1'b1;
            bus.I_raddr  = ASIZE'(a);
            exp_q.push_back(exp_vec(a));
            iss_q.push_back(cyc);
            tick();
        end
        bus.I_rd_req = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
            iss_q.delete();
        end
    endtask

    // scoreboard monitor: every readout beat must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && bus.O_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rvalid got=1 want=0 data=%h", bus.O_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = iss_q.pop_front();
                if (bus.O_rdata !== mon_e || (cyc - mon_t) != 3) begin
                    fails++;
                    $display("FAIL drain_data got=%h want=%h latency=%0d want_latency=3",
                             bus.O_rdata, mon_e, cyc - mon_t);
                end
            end
        end
    end

    initial begin
        int len;
        int nb;
        bus.I_start = 1'b0; bus.I_len = '0; bus.I_first_flag = 1'b0; bus.I_dv = 1'b0;
        bus.I_din = '0; bus.I_done = 1'b0; bus.I_rd_req = 1'b0; bus.I_raddr = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", longint'(bus.O_busy), 0);
        chk("reset_rvalid", longint'(bus.O_rvalid), 0);
        checks++;
        if (bus.O_rdata !== '0) begin
            fails++;
            $display("FAIL reset_rdata got=%h want=0", bus.O_rdata);
        end

        // two passes over an 8-word row: lane index, then +1
        do_start(7, 1'b1);
        chk("acc_busy", longint'(bus.O_busy), 1);
        for (int i = 0; i < 8; i++) beat(vec_lane_idx(), 1'b0);
        for (int i = 0; i < 8; i++) beat(vec_const(1), 1'b0);
        end_row();
        drain(0, 7);

        // single-word row hammered back-to-back
        do_start(0, 1'b1);
        for (int i = 0; i < 10; i++) beat(vec_const(5), 1'b0);
        end_row();
        drain(0, 0);

        // three-word row with random gaps; last beat carries I_done
        do_start(2, 1'b1);
        for (int i = 0; i < 9; i++) begin
            beat(vec_const(-3), i == 8);
            if (i != 8) repeat ($urandom_range(0, 2)) tick();
        end
        wait_rdy();
        drain(0, 2);

        // repeated full-scale input on one word: clamps or wraps depending on the build
        do_start(0, 1'b1);
        for (int i = 0; i < 6; i++) beat(vec_const(2047), 1'b0);
        end_row();
        drain(0, 0);

        // known row, then reset with beats in flight, then a fresh short row
        do_start(7, 1'b1);
        for (int i = 0; i < 8; i++) beat(vec_lane_idx(), 1'b0);
        end_row();
        do_start(7, 1'b0);
        for (int i = 0; i < 3; i++) beat(vec_const(100), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midacc_reset_busy", longint'(bus.O_busy), 0);
        tick();
        do_start(3, 1'b1);
        for (int i = 0; i < 4; i++) beat(vec_const(7), 1'b0);
        end_row();
        drain(0, 7);

        // random rows with random data and gaps; a stray I_dv in RDY must change nothing
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(0, 7);
            nb  = $urandom_range(len + 1, 3 * (len + 1) + 2);
            do_start(len, 1'b1);
            for (int i = 0; i < nb; i++) begin
                beat(vec_rand(), 1'b0);
                repeat ($urandom_range(0, 1)) tick();
            end
            end_row();
            bus.I_dv  = 1'b1;
            bus.I_din = vec_rand();
            tick();
            bus.I_dv = 1'b0;
            drain(0, len);
        end

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
